// File: rtl/ram512_arbiter_pkg.sv
// ram512_arbiter_pkg: FSM states and parameter range check shared by the RAM arbiter
package ram512_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  function automatic bit wait_ok(input int w);
    return (w >= WAIT_MIN) && (w <= WAIT_MAX);
  endfunction
endpackage

// File: rtl/ram512_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant; prio flips to the loser on every handshake
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_ready0,
  output logic o_ready1,
  output logic o_grant
);
  logic r_prio;
  logic w_v0, w_v1;
  assign w_v0     = i_en & i_valid0;
  assign w_v1     = i_en & i_valid1;
  assign o_ready0 = w_v0 & (!r_prio | !w_v1);
  assign o_ready1 = w_v1 & (r_prio | !w_v0);
  assign o_grant  = o_ready1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_prio <= 1'b0;
    else if (o_ready0 | o_ready1) r_prio <= o_ready0;
endmodule

// File: rtl/ram512_arbiter.sv
// ram512_arbiter: round-robin two-port sequencer in front of a single ram512
module ram512_arbiter
  import ram512_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_w,
  output logic              mem_r,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out
);
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
  if (!wait_ok(WAIT_CYCLES)) begin : g_bad_wait
    $error("WAIT_CYCLES must be 1..15");
  end
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_grant;
  logic        w_ready0, w_ready1, w_grant, w_we;
  logic [DATA_W-1:0] w_rdata;
  rr_arbiter_2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (r_state == IDLE),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .o_ready0 (w_ready0),
    .o_ready1 (w_ready1),
    .o_grant  (w_grant)
  );
  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign w_we       = w_grant ? req1_we : req0_we;
  // d_out floats unless r is high, so writes capture zero instead
  assign w_rdata    = mem_w ? '0 : mem_d_out;
  // mem_add/mem_d_in double as the request latch for the whole access
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_grant    <= 1'b0;
      mem_en     <= 1'b0;
      mem_w      <= 1'b0;
      mem_r      <= 1'b0;
      mem_add    <= '0;
      mem_d_in   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_ready0 | w_ready1) begin
          r_grant  <= w_grant;
          r_cnt    <= '0;
          mem_en   <= 1'b1;
          mem_w    <= w_we;
          mem_r    <= !w_we;
          mem_add  <= w_grant ? req1_addr : req0_addr;
          mem_d_in <= w_we ? (w_grant ? req1_wdata : req0_wdata) : '0;
          r_state  <= ACCESS;
        end
        ACCESS: if (r_cnt == LAST) begin
          mem_en     <= 1'b0;
          mem_w      <= 1'b0;
          mem_r      <= 1'b0;
          mem_add    <= '0;
          mem_d_in   <= '0;
          rsp0_valid <= !r_grant;
          rsp1_valid <= r_grant;
          rsp0_rdata <= r_grant ? '0 : w_rdata;
          rsp1_rdata <= r_grant ? w_rdata : '0;
          r_state    <= RESP;
        end else r_cnt <= r_cnt + 4'd1;
        RESP: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          rsp0_rdata <= '0;
          rsp1_rdata <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
